// File: rtl/decode_reg_read_stage.sv
// Decode / register-read stage: picks source indices, reads the register
// file, forwards writeback results, stalls on scoreboard hazards and holds
// the operands in an output register toward execute.

package decode_pkg;
  localparam int INSTR_REG_W = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic {CSR_SEL_REG = 1'b0, CSR_SEL_IMM = 1'b1} csr_sel_e;

  typedef struct packed {
    csr_sel_e    input_select;
    logic [11:0] addr;
  } csr_t;

  typedef struct packed {
    logic [INSTR_REG_W-1:0] rs2;
    logic [INSTR_REG_W-1:0] rs1;
    logic [INSTR_REG_W-1:0] rd;
  } r_instr_t;

  typedef struct packed {
    r_instr_t r_instr;
  } params_t;

  typedef struct packed {
    logic [6:0]  opcode;
    csr_t        csr;
    params_t     params;
    logic [31:0] imm;
  } instr_packet;
endpackage

// One source operand: x0 forcing, writeback bypass and hazard detection.
module decode_operand_sel #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_WB     = 2
) (
  input  logic [REG_ADDR_W-1:0]             idx_i,
  input  logic                              pend_i,
  input  logic [XLEN-1:0]                   rf_data_i,
  input  logic [NUM_WB-1:0]                 wb_valid_i,
  input  logic [NUM_WB-1:0][REG_ADDR_W-1:0] wb_rd_i,
  input  logic [NUM_WB-1:0][XLEN-1:0]       wb_data_i,
  output logic [XLEN-1:0]                   data_o,
  output logic                              busy_o
);
  logic hit;

  // Lowest-numbered matching writeback port beats the register file; x0 is 0.
  always_comb begin
    hit    = 1'b0;
    data_o = rf_data_i;
    for (int k = 0; k < NUM_WB; k++) begin
      if (!hit && wb_valid_i[k] && (wb_rd_i[k] == idx_i)) begin
        hit    = 1'b1;
        data_o = wb_data_i[k];
      end
    end
    if (idx_i == '0) data_o = '0;
  end

  // Pending producer with no bypass this cycle blocks the source.
  assign busy_o = (idx_i != '0) && pend_i && !hit;
endmodule

module decode_reg_read_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_WB     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  instr_packet                       in_instr,
  input  logic                              in_uses_rs2,
  input  logic                              in_writes_rd,
  output logic [REG_ADDR_W-1:0]             rf_raddr1,
  output logic [REG_ADDR_W-1:0]             rf_raddr2,
  input  logic [XLEN-1:0]                   rf_rdata1,
  input  logic [XLEN-1:0]                   rf_rdata2,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB-1:0][REG_ADDR_W-1:0] wb_rd,
  input  logic [NUM_WB-1:0][XLEN-1:0]       wb_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output instr_packet                       out_instr,
  output logic [REG_ADDR_W-1:0]             out_rs1,
  output logic [REG_ADDR_W-1:0]             out_rs2,
  output logic [XLEN-1:0]                   out_rs1_data,
  output logic [XLEN-1:0]                   out_rs2_data
);
  localparam int NREG = 2**REG_ADDR_W;

  logic [1:0][REG_ADDR_W-1:0] src_idx;
  logic [1:0][XLEN-1:0]       src_rf;
  logic [1:0][XLEN-1:0]       src_data;
  logic [1:0]                 src_busy;
  logic [REG_ADDR_W-1:0]      rd_idx;
  logic                       rs1_zero;
  logic                       hazard;
  logic                       accept;

  logic [NREG-1:0]            sb_q, sb_d;
  logic                       out_valid_q;
  instr_packet                out_instr_q;
  logic [REG_ADDR_W-1:0]      out_rs1_q, out_rs2_q;
  logic [XLEN-1:0]            out_rs1_data_q, out_rs2_data_q;

  // LUI and immediate-form CSR ops have no rs1; their rs1 field is not a register.
  always_comb begin
    rs1_zero   = (in_instr.opcode == OPCODE_LUI) ||
                 ((in_instr.opcode == OPCODE_SYSTEM) &&
                  (in_instr.csr.input_select == CSR_SEL_IMM));
    src_idx[0] = rs1_zero ? '0 : in_instr.params.r_instr.rs1[REG_ADDR_W-1:0];
    src_idx[1] = in_instr.params.r_instr.rs2[REG_ADDR_W-1:0];
    rd_idx     = in_instr.params.r_instr.rd[REG_ADDR_W-1:0];
  end

  assign rf_raddr1 = src_idx[0];
  assign rf_raddr2 = src_idx[1];
  assign src_rf[0] = rf_rdata1;
  assign src_rf[1] = rf_rdata2;

  for (genvar s = 0; s < 2; s++) begin : g_src
    decode_operand_sel #(
      .XLEN      (XLEN),
      .REG_ADDR_W(REG_ADDR_W),
      .NUM_WB    (NUM_WB)
    ) u_sel (
      .idx_i     (src_idx[s]),
      .pend_i    (sb_q[src_idx[s]]),
      .rf_data_i (src_rf[s]),
      .wb_valid_i(wb_valid),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .data_o    (src_data[s]),
      .busy_o    (src_busy[s])
    );
  end

  assign hazard   = src_busy[0] | (in_uses_rs2 & src_busy[1]);
  assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: clears first, new producer set wins, flush wipes all.
  always_comb begin
    sb_d = sb_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) sb_d[wb_rd[k]] = 1'b0;
    end
    if (accept && in_writes_rd && (rd_idx != '0)) sb_d[rd_idx] = 1'b1;
    if (flush) sb_d = '0;
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  // Output register: load on accept, hold under backpressure, drop when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
    end else if (flush) begin
      out_valid_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_instr_q    <= in_instr;
      out_rs1_q      <= src_idx[0];
      out_rs2_q      <= src_idx[1];
      out_rs1_data_q <= src_data[0];
      out_rs2_data_q <= src_data[1];
    end else if (out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_rs1      = out_rs1_q;
  assign out_rs2      = out_rs2_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
endmodule

// File: tb/tb_decode_reg_read_stage.sv
// Directed bench for decode_reg_read_stage with hand-computed expectations.
module tb_decode_reg_read_stage;
  import decode_pkg::*;

  logic              clk, rst_n, flush;
  logic              in_valid, in_ready, in_uses_rs2, in_writes_rd;
  instr_packet       in_instr, out_instr;
  logic [4:0]        rf_raddr1, rf_raddr2, out_rs1, out_rs2;
  logic [31:0]       rf_rdata1, rf_rdata2, out_rs1_data, out_rs2_data;
  logic [1:0]        wb_valid;
  logic [1:0][4:0]   wb_rd;
  logic [1:0][31:0]  wb_data;
  logic              out_valid, out_ready;
  logic [31:0]       rf [32];
  int                n_chk, n_pass;

  decode_reg_read_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_WB(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register file model
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_packet mk(input logic [6:0] op, input csr_sel_e sel,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    instr_packet p;
    p = '0;
    p.opcode = op;
    p.csr.input_select = sel;
    p.params.r_instr.rd = rd;
    p.params.r_instr.rs1 = rs1;
    p.params.r_instr.rs2 = rs2;
    p.imm = 32'hA5A5_0000 | {27'd0, rd};
    return p;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'h333; rf[6] = 32'h66;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_uses_rs2 = 1'b0;
    in_writes_rd = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = '0; wb_rd = '0; wb_data = '0;

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rs1_data", out_rs1_data, 0);
    chk("rst_out_rs2", out_rs2, 0);
    chk("rst_sb", dut.sb_q, 0);
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    in_valid = 1'b1; in_uses_rs2 = 1'b1; in_writes_rd = 1'b1;
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd3, 5'd1, 5'd2);
    #1;
    chk("add_in_ready", in_ready, 1);
    chk("add_raddr1", rf_raddr1, 1);
    chk("add_raddr2", rf_raddr2, 2);
    step();
    chk("add_out_valid", out_valid, 1);
    chk("add_rs1_data", out_rs1_data, 5);
    chk("add_rs2_data", out_rs2_data, 7);
    chk("add_out_rs1", out_rs1, 1);
    chk("add_sb3", dut.sb_q[3], 1);

    // LUI x4 with rs1 field 9
    in_uses_rs2 = 1'b0;
    in_instr = mk(OPCODE_LUI, CSR_SEL_REG, 5'd4, 5'd9, 5'd0);
    #1;
    chk("lui_raddr1", rf_raddr1, 0);
    step();
    chk("lui_out_rs1", out_rs1, 0);
    chk("lui_rs1_data", out_rs1_data, 0);
    chk("lui_sb4", dut.sb_q[4], 1);
    chk("lui_out_instr", out_instr, mk(OPCODE_LUI, CSR_SEL_REG, 5'd4, 5'd9, 5'd0));

    // CSRRWI x0 with rs1 field 0x1F
    in_instr = mk(OPCODE_SYSTEM, CSR_SEL_IMM, 5'd0, 5'd31, 5'd0);
    step();
    chk("csr_out_rs1", out_rs1, 0);
    chk("csr_rs1_data", out_rs1_data, 0);
    chk("csr_sb0", dut.sb_q[0], 0);

    // ADD x5,x3,x0 stalls on pending x3
    in_uses_rs2 = 1'b1;
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd5, 5'd3, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("raw_stall_ready", in_ready, 0);
      step();
    end
    chk("raw_drained", out_valid, 0);
    wb_valid = 2'b10; wb_rd[1] = 5'd3; wb_data[1] = 32'hDEAD;
    #1;
    chk("raw_bypass_ready", in_ready, 1);
    step();
    wb_valid = '0;
    chk("raw_out_valid", out_valid, 1);
    chk("raw_rs1_data", out_rs1_data, 32'hDEAD);
    chk("raw_rs2_data", out_rs2_data, 0);
    chk("raw_sb3", dut.sb_q[3], 0);
    chk("raw_sb5", dut.sb_q[5], 1);

    // Both ports write x6; port 0 wins. OR x7,x6,x6
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd7, 5'd6, 5'd6);
    wb_valid = 2'b11; wb_rd[0] = 5'd6; wb_rd[1] = 5'd6;
    wb_data[0] = 32'h11; wb_data[1] = 32'h22;
    step();
    wb_valid = '0;
    chk("dual_rs1_data", out_rs1_data, 32'h11);
    chk("dual_rs2_data", out_rs2_data, 32'h11);
    chk("dual_sb7", dut.sb_q[7], 1);

    // Backpressure: outputs hold for 4 cycles
    out_ready = 1'b0;
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd9, 5'd1, 5'd2);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_rs1_data", out_rs1_data, 32'h11);
      chk("bp_out_rs1", out_rs1, 6);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("b2b0_rs1_data", out_rs1_data, 5);
    chk("b2b0_rs2_data", out_rs2_data, 7);
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd10, 5'd2, 5'd1);
    #1;
    chk("b2b1_in_ready", in_ready, 1);
    step();
    chk("b2b1_out_valid", out_valid, 1);
    chk("b2b1_rs1_data", out_rs1_data, 7);
    chk("b2b1_rs2_data", out_rs2_data, 5);

    // Set and clear of x8 in the same cycle: set wins
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd8, 5'd0, 5'd0);
    wb_valid = 2'b01; wb_rd[0] = 5'd8; wb_data[0] = 32'h88;
    step();
    wb_valid = '0;
    chk("setwin_sb8", dut.sb_q[8], 1);

    // Flush with out_valid=1 and sb[7]=1
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd12, 5'd1, 5'd2);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sb", dut.sb_q, 0);

    // Async reset in the middle of a stall
    in_valid = 1'b1;
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd11, 5'd1, 5'd2);
    out_ready = 1'b0;
    step();
    in_instr = mk(OPCODE_OP, CSR_SEL_REG, 5'd13, 5'd11, 5'd0);
    #1;
    chk("stall11_in_ready", in_ready, 0);
    chk("stall11_out_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sb", dut.sb_q, 0);
    chk("async_rst_rs1_data", out_rs1_data, 0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
